// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and add/sub mode constants for the digit-serial adder
package serial_addsub_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_digit_adder.sv
// digit_adder: DIGIT-bit combinational ripple of full adders, also exposing the carry into the MSB
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] sum,
   output logic             co,
   output logic             cm
);
   logic [DIGIT:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign co = c[DIGIT];
   assign cm = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per cycle, registered sum/carry/overflow
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;
   state_t           state;
   logic [WIDTH-1:0] ar, br, sr, sr_nx;
   logic [IW-1:0]    idx;
   logic             cr, md;
   logic [DIGIT-1:0] dsum;
   logic             dco, dcm;
   digit_adder #(.DIGIT(DIGIT)) u_da (
      .x(ar[DIGIT-1:0]),
      .y(br[DIGIT-1:0]),
      .ci(cr),
      .sum(dsum),
      .co(dco),
      .cm(dcm)
   );
   // new digit enters at the top so the LSB digit ends up at the bottom after NDIG shifts
   assign sr_nx = WIDTH'({dsum, sr} >> DIGIT);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         ar    <= '0;
         br    <= '0;
         sr    <= '0;
         idx   <= '0;
         cr    <= 1'b0;
         md    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= start ? RUN : IDLE;
               if (start) begin
                  ar   <= a;
                  br   <= (sub == MODE_SUB) ? ~b : b;
                  cr   <= cin ^ sub;
                  md   <= sub;
                  idx  <= '0;
                  busy <= 1'b1;
               end
            end
            RUN: begin
               ar  <= ar >> DIGIT;
               br  <= br >> DIGIT;
               sr  <= sr_nx;
               cr  <= dco;
               idx <= idx + 1'b1;
               if (idx == IW'(NDIG - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  s     <= sr_nx;
                  cout  <= dco ^ md;
                  ovf   <= dco ^ dcm;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub at DIGIT=4, 1 and 16 against a reference model
module tb_serial_addsub;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  st = '0;
   logic        sub = 1'b0, cin = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [2:0]  busy, dn, cout, ovf;
   logic [15:0] s_o [3];
   int checks = 0;
   int failures = 0;
   logic [17:0] q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy[0]), .done(dn[0]), .s(s_o[0]), .cout(cout[0]), .ovf(ovf[0]));
   serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy[1]), .done(dn[1]), .s(s_o[1]), .cout(cout[1]), .ovf(ovf[1]));
   serial_addsub #(.WIDTH(16), .DIGIT(16)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy[2]), .done(dn[2]), .s(s_o[2]), .cout(cout[2]), .ovf(ovf[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // returns {cout, ovf, s}; cout is borrow in subtract mode
   function automatic logic [17:0] ref_op(input logic sb, input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [16:0] r;
      logic v;
      if (!sb) begin
         r = {1'b0, x} + {1'b0, y} + 17'(c);
         v = (x[15] == y[15]) && (r[15] != x[15]);
      end else begin
         r = {1'b0, x} - {1'b0, y} - 17'(c);
         v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      return {r[16], v, r[15:0]};
   endfunction

   function automatic void push(input int sel, input logic [17:0] e);
      if (sel == 0) q0.push_back(e);
      else if (sel == 1) q1.push_back(e);
      else q2.push_back(e);
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (dn[i]) begin
            int sz;
            logic [17:0] e;
            sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (sz == 0) chk($sformatf("spurious_done%0d", i), 32'(dn[i]), 32'd0);
            else begin
               e = (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
               chk($sformatf("s%0d", i), 32'(s_o[i]), 32'(e[15:0]));
               chk($sformatf("cout%0d", i), 32'(cout[i]), 32'(e[17]));
               chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(e[16]));
            end
         end
      end
   end

   task automatic op(input int sel, input logic sb, input logic [15:0] x, input logic [15:0] y, input logic c);
      int n;
      int lat;
      lat = (sel == 0) ? 4 : (sel == 1) ? 16 : 1;
      @(negedge clk);
      sub = sb; a = x; b = y; cin = c; st[sel] = 1'b1;
      push(sel, ref_op(sb, x, y, c));
      @(negedge clk);
      st = '0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      chk("busy_after_accept", 32'(busy[sel]), 32'd1);
      n = 0;
      while (!dn[sel] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency%0d", sel), 32'(n), 32'(lat));
   endtask

   initial begin
      logic [17:0] e;
      repeat (2) begin
         @(negedge clk);
         st = 3'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_s", 32'(s_o[i]), 32'd0);
         chk("rst_cout", 32'(cout[i]), 32'd0);
         chk("rst_ovf", 32'(ovf[i]), 32'd0);
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_done", 32'(dn[i]), 32'd0);
      end
      st = '0;
      rst_n = 1'b1;
      op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      op(0, 1'b0, 16'h1234, 16'h4321, 1'b1);
      op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      op(0, 1'b1, 16'h8000, 16'h0001, 1'b0);
      op(0, 1'b1, 16'h0005, 16'h0007, 1'b0);
      op(0, 1'b1, 16'h0010, 16'h0001, 1'b1);
      // start held high: one result every 5 cycles, operand changes mid-run ignored
      @(negedge clk);
      st[0] = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      push(0, ref_op(1'b0, 16'h1111, 16'h2222, 1'b0));
      @(negedge clk);
      sub = 1'b1; a = 16'h0300; b = 16'h0400; cin = 1'b1;
      push(0, ref_op(1'b1, 16'h0300, 16'h0400, 1'b1));
      repeat (3) @(negedge clk);
      chk("hs_done_early", 32'(dn[0]), 32'd0);
      @(negedge clk);
      chk("hs_done1", 32'(dn[0]), 32'd1);
      @(negedge clk);
      chk("hs_busy2", 32'(busy[0]), 32'd1);
      sub = 1'b0; a = 16'h8000; b = 16'h8000; cin = 1'b1;
      push(0, ref_op(1'b0, 16'h8000, 16'h8000, 1'b1));
      repeat (3) @(negedge clk);
      chk("hs_done_early2", 32'(dn[0]), 32'd0);
      @(negedge clk);
      chk("hs_done2", 32'(dn[0]), 32'd1);
      @(negedge clk);
      st = '0; a = 16'hDEAD; b = 16'hBEEF;
      chk("hs_busy3", 32'(busy[0]), 32'd1);
      repeat (3) @(negedge clk);
      chk("hs_done_early3", 32'(dn[0]), 32'd0);
      @(negedge clk);
      chk("hs_done3", 32'(dn[0]), 32'd1);
      @(negedge clk);
      chk("hs_idle", 32'(busy[0]), 32'd0);
      // abort: reset at edge k+2 of a run, no done pulse may follow
      @(negedge clk);
      st[0] = 1'b1; sub = 1'b0; a = 16'h4444; b = 16'h5555;
      @(negedge clk);
      st = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort_done", 32'(dn[0]), 32'd0);
         chk("abort_s", 32'(s_o[0]), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         op(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         op(1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         op(2, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      end
      repeat (3) @(negedge clk);
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q2_empty", 32'(q2.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
